// File: rtl/loader_pkg.sv
// Shared types and constants for the program-ROM loader and its write sequencer.
// State predicates live here so the loader and its output registers decode states the same way.
package loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        EDIT_ON,
        WAIT_BYTE,
        SETUP,
        STROBE,
        RELEASE,
        WAIT_SUM,
        EDIT_OFF,
        RUN_P,
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SETUP,
        SEQ_STROBE,
        SEQ_RELEASE
    } seq_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_SUM   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    localparam int unsigned BYTES_PER_INSTR = 4;

    function automatic logic is_busy(input loader_state_t st);
        return !(st inside {IDLE, DONE, ERR});
    endfunction

    function automatic logic takes_data(input loader_state_t st);
        return st inside {HDR, WAIT_BYTE, WAIT_SUM};
    endfunction

    // edit covers one cycle ahead of the first byte until the checksum is taken
    function automatic logic in_edit_window(input loader_state_t st);
        return st inside {EDIT_ON, WAIT_BYTE, SETUP, STROBE, RELEASE, WAIT_SUM};
    endfunction

endpackage

// File: rtl/rom_write_sequencer.sv
// Turns a one-cycle write request into the ROM setup / strobe / release sequence.
// send is registered; done is high during the release cycle.
module rom_write_sequencer
    import loader_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clear,
    output logic send,
    output logic done
);

    seq_state_t seq_q, seq_d;
    logic       send_q;

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            SEQ_IDLE:    if (req) seq_d = SEQ_SETUP;
            SEQ_SETUP:   seq_d = SEQ_STROBE;
            SEQ_STROBE:  seq_d = SEQ_RELEASE;
            SEQ_RELEASE: seq_d = SEQ_IDLE;
            default:     seq_d = SEQ_IDLE;
        endcase
        if (clear) seq_d = SEQ_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= SEQ_IDLE;
            send_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            send_q <= (seq_d == SEQ_STROBE);
        end
    end

    assign send = send_q;
    assign done = (seq_q == SEQ_RELEASE);

endmodule

// File: rtl/rom_program_loader.sv
// Loads a framed byte stream (count, 4N program bytes, XOR checksum) into the CPU program ROM
// through its edit/unit/code/send port, then optionally pulses run.
module rom_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_INSTR = 64,
    parameter bit          AUTO_RUN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       edit,
    output logic [7:0] unit,
    output logic [7:0] code,
    output logic       send,
    output logic       run,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    loader_state_t state_q, state_d;

    logic [7:0] addr_q, addr_d;
    logic [8:0] total_q, total_d;
    logic [7:0] sum_q, sum_d;
    logic       sum_ok_q, sum_ok_d;
    logic [7:0] unit_q, unit_d;
    logic [7:0] code_q, code_d;
    logic [1:0] err_code_q, err_code_d;

    logic s_ready_q, edit_q, run_q, busy_q, done_q, err_q;

    logic accept;
    logic wr_req;
    logic wr_clear;
    logic wr_done;
    logic seq_send;

    assign accept = s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        total_d    = total_q;
        sum_d      = sum_q;
        sum_ok_d   = sum_ok_q;
        unit_d     = unit_q;
        code_d     = code_q;
        err_code_d = err_code_q;
        wr_req     = 1'b0;
        wr_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR;
                    addr_d  = 8'd0;
                    sum_d   = 8'd0;
                end
            end
            HDR: begin
                if (accept) begin
                    if (s_data == 8'd0 || 32'(s_data) > MAX_INSTR) begin
                        state_d    = ERR;
                        err_code_d = ERR_COUNT;
                    end else begin
                        total_d = 9'(32'(s_data) * BYTES_PER_INSTR);
                        state_d = EDIT_ON;
                    end
                end
            end
            EDIT_ON: state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (accept) begin
                    code_d  = s_data;
                    unit_d  = addr_q;
                    sum_d   = sum_q ^ s_data;
                    wr_req  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = RELEASE;
            RELEASE: begin
                if (wr_done) begin
                    addr_d = addr_q + 8'd1;
                    // 9-bit compare: a full 64-instruction program ends at 256
                    if ({1'b0, addr_q} + 9'd1 == total_q) begin
                        state_d = WAIT_SUM;
                    end else begin
                        state_d = WAIT_BYTE;
                    end
                end
            end
            WAIT_SUM: begin
                if (accept) begin
                    sum_ok_d = (s_data == sum_q);
                    state_d  = EDIT_OFF;
                end
            end
            EDIT_OFF: begin
                if (!sum_ok_q) begin
                    state_d    = ERR;
                    err_code_d = ERR_SUM;
                end else if (AUTO_RUN) begin
                    state_d = RUN_P;
                end else begin
                    state_d = DONE;
                end
            end
            RUN_P: state_d = DONE;
            DONE, ERR: begin
                if (start) begin
                    state_d    = HDR;
                    addr_d     = 8'd0;
                    sum_d      = 8'd0;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // abort outranks start and any in-flight ROM write
        if (abort && is_busy(state_q)) begin
            state_d    = ERR;
            err_code_d = ERR_ABORT;
            wr_req     = 1'b0;
            wr_clear   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 8'd0;
            total_q    <= 9'd0;
            sum_q      <= 8'd0;
            sum_ok_q   <= 1'b0;
            unit_q     <= 8'd0;
            code_q     <= 8'd0;
            err_code_q <= ERR_NONE;
            s_ready_q  <= 1'b0;
            edit_q     <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            sum_q      <= sum_d;
            sum_ok_q   <= sum_ok_d;
            unit_q     <= unit_d;
            code_q     <= code_d;
            err_code_q <= err_code_d;
            s_ready_q  <= takes_data(state_d);
            edit_q     <= in_edit_window(state_d);
            run_q      <= (state_d == RUN_P);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
        end
    end

    rom_write_sequencer u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .clear (wr_clear),
        .send  (seq_send),
        .done  (wr_done)
    );

    assign s_ready  = s_ready_q;
    assign edit     = edit_q;
    assign unit     = unit_q;
    assign code     = code_q;
    assign send     = seq_send;
    assign run      = run_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_rom_program_loader.sv
// Scoreboard bench for rom_program_loader: expected ROM writes are queued as the frame is
// built and retired by a monitor as each send strobe appears.
module tb_rom_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, edit, send, run, busy, done, err;
    logic [7:0] unit, code;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  prog[256];
    bit          toggle_mode = 1'b0;
    bit          phase = 1'b0;
    int          send_cnt = 0;
    int          run_cnt = 0;
    int          edit_cnt = 0;
    logic        prev_send = 1'b0;
    logic        prev_edit = 1'b0;
    logic [7:0]  prev_unit = 8'h00;
    logic [7:0]  prev_code = 8'h00;
    bit          timed_out;

    rom_program_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .edit     (edit),
        .unit     (unit),
        .code     (code),
        .send     (send),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // retire a stream byte on each handshake
    initial forever begin
        @(posedge clk);
        if (rst_n && s_valid && s_ready && tx_q.size() > 0) void'(tx_q.pop_front());
    end

    initial forever begin
        @(negedge clk);
        phase = ~phase;
        if (tx_q.size() > 0 && (!toggle_mode || phase)) begin
            s_valid = 1'b1;
            s_data  = tx_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
        end
    end

    // ROM write monitor and scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_send = 1'b0;
            prev_edit = 1'b0;
        end else begin
            if (edit) edit_cnt++;
            if (run) run_cnt++;
            if (send) begin
                send_cnt++;
                checks++;
                if (prev_send) begin
                    errors++;
                    $display("FAIL send_width: send=1 two cycles running at unit=%h, required 1-cycle pulse", unit);
                end
                checks++;
                if (!(edit && prev_edit)) begin
                    errors++;
                    $display("FAIL edit_window: edit=%b prev_edit=%b at send, required 1 and 1", edit, prev_edit);
                end
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_extra: got unit=%h code=%h, required no write", unit, code);
                end else begin
                    logic [15:0] exp;
                    exp = exp_wr.pop_front();
                    if ({unit, code} !== exp) begin
                        errors++;
                        $display("FAIL write: got unit=%h code=%h, required unit=%h code=%h",
                                 unit, code, exp[15:8], exp[7:0]);
                    end
                end
            end
            if (prev_send) begin
                checks++;
                if (unit !== prev_unit || code !== prev_code) begin
                    errors++;
                    $display("FAIL release_hold: unit=%h code=%h, required unit=%h code=%h",
                             unit, code, prev_unit, prev_code);
                end
            end
            prev_send = send;
            prev_edit = edit;
            prev_unit = unit;
            prev_code = code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // queue a frame of n instructions from prog[]; the first n_exp bytes are expected in ROM
    task automatic queue_frame(input int n, input logic [7:0] sum_flip, input int n_exp);
        logic [7:0] sum;
        sum = 8'h00;
        tx_q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            tx_q.push_back(prog[i]);
            sum ^= prog[i];
            if (i < n_exp) exp_wr.push_back({8'(i), prog[i]});
        end
        tx_q.push_back(sum ^ sum_flip);
    endtask

    task automatic wait_end(input int bound);
        int cyc;
        cyc = 0;
        timed_out = 1'b0;
        while (!(done || err)) begin
            tick();
            cyc++;
            if (cyc > bound) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_ready, edit, send, run, busy, done, err, err_code, unit, code} !== 27'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h, required 0", {s_ready, edit, send, run, busy,
                     done, err, err_code, unit, code});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s_ready, edit, send, run, busy, done, err, err_code, unit, code} !== 27'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%h, required 0", {s_ready, edit, send, run, busy,
                     done, err, err_code, unit, code});
        end
    endtask

    task automatic test_single();
        int r0, s0;
        r0 = run_cnt;
        s0 = send_cnt;
        prog[0] = 8'h00; prog[1] = 8'h07; prog[2] = 8'h07; prog[3] = 8'h00;
        queue_frame(1, 8'h00, 4);
        do_start();
        wait_end(200);
        checks++;
        if (timed_out) begin errors++; $display("FAIL single_timeout: no done/err, required done"); end
        checks++;
        if ({done, err, err_code} !== 4'b1000) begin
            errors++;
            $display("FAIL single_status: done=%b err=%b code=%0d, required done=1 err=0 code=0",
                     done, err, err_code);
        end
        checks++;
        if (run_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL single_run: run pulses=%0d, required 1", run_cnt - r0);
        end
        checks++;
        if (send_cnt - s0 !== 4 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL single_writes: sends=%0d pending=%0d, required 4 and 0",
                     send_cnt - s0, exp_wr.size());
        end
        checks++;
        if (edit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_edit: edit=%b busy=%b, required 0 0", edit, busy);
        end
    endtask

    task automatic test_toggle();
        int s0;
        s0 = send_cnt;
        for (int i = 0; i < 8; i++) begin
            prog[4*i]   = 8'h01;
            prog[4*i+1] = 8'h00;
            prog[4*i+2] = 8'(8'h10 + i);
            prog[4*i+3] = (i == 7) ? 8'h07 : 8'(8'h11 + i);
        end
        toggle_mode = 1'b1;
        queue_frame(8, 8'h00, 32);
        do_start();
        wait_end(1000);
        toggle_mode = 1'b0;
        checks++;
        if (timed_out || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_done: done=%b err_code=%0d, required done=1", done, err_code);
        end
        checks++;
        if (send_cnt - s0 !== 32 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL toggle_writes: sends=%0d pending=%0d, required 32 and 0",
                     send_cnt - s0, exp_wr.size());
        end
    endtask

    task automatic test_max();
        int s0;
        s0 = send_cnt;
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom_range(0, 255));
        queue_frame(64, 8'h00, 256);
        do_start();
        wait_end(3000);
        checks++;
        if (timed_out || done !== 1'b1 || send_cnt - s0 !== 256 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL max_load: done=%b sends=%0d pending=%0d, required 1 256 0",
                     done, send_cnt - s0, exp_wr.size());
        end
        checks++;
        if (unit !== 8'hFF) begin
            errors++;
            $display("FAIL max_last_unit: unit=%h, required ff", unit);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] counts[2];
        counts[0] = 8'h00;
        counts[1] = 8'h41;
        for (int k = 0; k < 2; k++) begin
            int e0, s0;
            e0 = edit_cnt;
            s0 = send_cnt;
            tx_q.push_back(counts[k]);
            do_start();
            wait_end(100);
            checks++;
            if (timed_out || {done, err, err_code} !== 4'b0101) begin
                errors++;
                $display("FAIL bad_count_%0h: done=%b err=%b code=%0d, required err=1 code=1",
                         counts[k], done, err, err_code);
            end
            checks++;
            if (edit_cnt !== e0 || send_cnt !== s0) begin
                errors++;
                $display("FAIL bad_count_rom_%0h: edit cycles=%0d sends=%0d, required 0 0",
                         counts[k], edit_cnt - e0, send_cnt - s0);
            end
        end
    endtask

    task automatic test_bad_sum();
        int r0, s0;
        r0 = run_cnt;
        s0 = send_cnt;
        prog[0] = 8'h00; prog[1] = 8'h07; prog[2] = 8'h07; prog[3] = 8'h00;
        queue_frame(1, 8'hFF, 4);
        do_start();
        wait_end(200);
        checks++;
        if (timed_out || {done, err, err_code} !== 4'b0110) begin
            errors++;
            $display("FAIL bad_sum_status: done=%b err=%b code=%0d, required err=1 code=2",
                     done, err, err_code);
        end
        checks++;
        if (send_cnt - s0 !== 4 || run_cnt !== r0 || edit !== 1'b0) begin
            errors++;
            $display("FAIL bad_sum_rom: sends=%0d runs=%0d edit=%b, required 4 0 0",
                     send_cnt - s0, run_cnt - r0, edit);
        end
    endtask

    task automatic test_abort();
        int r0, s0, cyc;
        r0 = run_cnt;
        s0 = send_cnt;
        for (int i = 0; i < 8; i++) prog[i] = 8'(8'hA0 + i);
        queue_frame(2, 8'h00, 5);
        do_start();
        cyc = 0;
        while (!(send && unit == 8'd4) && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL abort_reach: strobe of byte 5 not seen"); end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({send, edit, run, busy, err, err_code} !== 7'b0000111) begin
            errors++;
            $display("FAIL abort_next: send=%b edit=%b run=%b busy=%b err=%b code=%0d, required 0 0 0 0 1 3",
                     send, edit, run, busy, err, err_code);
        end
        tx_q.delete();
        repeat (4) tick();
        checks++;
        if (run_cnt !== r0 || send_cnt - s0 !== 5 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL abort_rom: runs=%0d sends=%0d pending=%0d, required 0 5 0",
                     run_cnt - r0, send_cnt - s0, exp_wr.size());
        end
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'h04;
        queue_frame(1, 8'h00, 4);
        do_start();
        wait_end(200);
        checks++;
        if (timed_out || {done, err, err_code} !== 4'b1000 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL abort_reload: done=%b code=%0d pending=%0d, required 1 0 0",
                     done, err_code, exp_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        int s0, r0, cyc;
        s0 = send_cnt;
        r0 = run_cnt;
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
        queue_frame(1, 8'h00, 4);
        do_start();
        cyc = 0;
        while (!(s_ready && send_cnt == s0 + 1) && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("FAIL rst_reach: WAIT_BYTE of byte 2 not seen"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, edit, send, run, busy, done, err, err_code, unit, code} !== 27'd0) begin
            errors++;
            $display("FAIL rst_async: outputs=%h, required 0", {s_ready, edit, send, run, busy,
                     done, err, err_code, unit, code});
        end
        tx_q.delete();
        exp_wr.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (run_cnt !== r0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet: runs=%0d busy=%b, required 0 0", run_cnt - r0, busy);
        end
        queue_frame(1, 8'h00, 4);
        do_start();
        wait_end(200);
        checks++;
        if (timed_out || done !== 1'b1 || exp_wr.size() !== 0 || {unit, code} !== 16'h0344) begin
            errors++;
            $display("FAIL rst_reload: done=%b pending=%0d unit=%h code=%h, required 1 0 03 44",
                     done, exp_wr.size(), unit, code);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_bad_count();
        test_bad_sum();
        test_abort();
        test_reset_mid();
        test_max();
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_program_loader.md
Name: rom_program_loader

Overview:
- Upstream feeder for the CPU's program-ROM edit port (edit/unit/code/send) and its RUN strobe.
- Accepts a framed byte stream over a valid/ready handshake: count byte N, then 4N program bytes (opcode, src1, src2, dst per instruction), then an XOR checksum byte.
- Writes each program byte to ROM with the setup/strobe/release sequence the CPU expects, then optionally pulses run.

Parameters:
- MAX_INSTR, 64, largest legal N; 4*MAX_INSTR must be ≤ 256.
- AUTO_RUN, 1, when 1, pulse run for one cycle after a good checksum.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR.
- abort  in  1  cancels a load in progress.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte this cycle.
- edit  out  1  ROM edit enable to the CPU.
- unit  out  8  ROM byte address.
- code  out  8  ROM byte data.
- send  out  1  ROM write strobe.
- run  out  1  one-cycle RUN pulse to the CPU.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERR.
- err_code  out  2  0 none, 1 bad count, 2 checksum mismatch, 3 aborted.

Behaviour:
- Reset values: all outputs 0; state IDLE; address and checksum registers 0.
- All outputs are registered. A byte transfers when s_valid && s_ready at a rising edge.
- s_ready is 1 only in HDR, WAIT_BYTE and WAIT_SUM.
- States and transitions:
  - IDLE: on start, go to HDR.
  - HDR: on accept, latch N. If N == 0 or N > MAX_INSTR, go to ERR with err_code 1; edit is never raised. Otherwise total = 4N, go to EDIT_ON.
  - EDIT_ON: edit = 1 for one cycle before the first byte; go to WAIT_BYTE.
  - WAIT_BYTE: on accept, code <= s_data, unit <= addr, sum <= sum ^ s_data; go to SETUP.
  - SETUP: send = 0, unit and code stable.
  - STROBE: send = 1 for exactly one cycle.
  - RELEASE: send = 0; addr <= addr + 1. If addr + 1 == total, go to WAIT_SUM; else go to WAIT_BYTE.
  - WAIT_SUM: on accept, compare s_data with sum; go to EDIT_OFF.
  - EDIT_OFF: edit = 0. Good checksum: go to RUN_P if AUTO_RUN, else DONE. Bad checksum: go to ERR with err_code 2.
  - RUN_P: run = 1 for one cycle; go to DONE.
- Cycle cost: 4 cycles per program byte minimum (WAIT_BYTE, SETUP, STROBE, RELEASE), longer if s_valid stalls. unit and code stay stable across SETUP, STROBE and RELEASE.
- Address: 8-bit; never wraps because 4N ≤ 256. The last address written is 4N-1.
- abort: honoured in any busy state, including mid-strobe. Next cycle: send = 0, edit = 0, run = 0; go to ERR with err_code 3. ROM bytes already written stay written.
- start while busy: ignored. start in DONE or ERR: clear done, err and err_code, reset addr and sum, go to HDR.
- abort and start in the same cycle while busy: abort wins.
- rst_n low at any time, including mid-operation: immediately return to reset values, drop edit and send, no run pulse.

Decomposition:
- Shared package loader_pkg holds:
  - state enum: IDLE, HDR, EDIT_ON, WAIT_BYTE, SETUP, STROBE, RELEASE, WAIT_SUM, EDIT_OFF, RUN_P, DONE, ERR;
  - err_code constants: ERR_NONE, ERR_COUNT, ERR_SUM, ERR_ABORT;
  - BYTES_PER_INSTR = 4.
- One sub-module is natural: rom_write_sequencer, the SETUP/STROBE/RELEASE strobe generator with a one-cycle write request in and a done pulse out. Counting and framing stay in the top.

Test Plan:
- Stream 0x01, 0x00, 0x07, 0x07, 0x00, then checksum 0x00 (XOR of the four program bytes), s_valid held high. Expect:
  - writes to unit 0..3 with code 00, 07, 07, 00, each send exactly 1 cycle wide;
  - edit high from 1 cycle before the first write to after the last;
  - one run pulse, then done = 1.
- N = 8, 32 bytes matching the CPU bench program (ADD with INPUT/REG operands, last dst OUTPUT = 0x07), correct checksum, s_valid toggled every other cycle. Expect addresses 0..31 in order, no write while s_valid is low, done = 1.
- Count byte 0x00, then separately 0x41 (N = 65) after restart. Expect ERR, err_code = 1, edit and send never asserted.
- N = 1, checksum byte wrong (0xFF vs expected 0x00). Expect 4 ROM writes, edit dropped, no run, err_code = 2.
- abort asserted in the STROBE cycle of byte 5 of N = 2. Expect next cycle send = 0, edit = 0, err_code = 3, run never pulses. Then start followed by a good stream. Expect a clean load from unit 0.
- rst_n pulled low during WAIT_BYTE of byte 2. Expect all outputs 0 asynchronously. After release, a fresh start loads correctly.
